ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage. It consumes the instruction, operands and flush/exception outputs of the ID/EX pipeline register.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers.
- Exports busy to the hazard unit, which stalls any MDU-class instruction in ID while an operation is in flight.
- Takes req (interrupt/exception entry) so that an instruction being cancelled never starts or writes.

Parameters:
- MULT_CYCLES, 5, cycles from an accepted mult/multu until HI/LO are written.
- DIV_CYCLES, 10, cycles from an accepted div/divu until HI/LO are written. Must be ≤ 15.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  exception/interrupt entry this cycle; the EX instruction is being cancelled.
- start  input  1  one-cycle pulse: EX holds a valid MDU op.
- op  input  3  operation code (package encoding).
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  operation in flight.
- HI  output  32  architectural HI (mfhi source).
- LO  output  32  architectural LO (mflo source).

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, state=IDLE, counter=0, pending results=0. Outputs are valid immediately on assertion, not at the next edge.
- FSM states: IDLE, BUSY.
- IDLE→BUSY: at the edge where start=1, req=0, and op is MULT, MULTU, DIV or DIVU.
  - Latch the computed result into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES, as appropriate.
- BUSY: counter decrements each edge. At the edge where counter==1:
  - HI←pend_hi, LO←pend_lo.
  - counter←0, state→IDLE.
- busy is registered: busy = (state==BUSY). It is high for exactly N cycles after the accepting edge.
  - New HI/LO are visible in the same cycle busy falls.
- mthi/mtlo: with start=1, req=0 and state IDLE, HI or LO ← A at the edge. Single cycle; busy stays 0.
- req=1: start is ignored that cycle. No state change, no HI/LO write.
- An operation already in BUSY when req rises completes normally. Its instruction has already committed past EX.
- start while BUSY: protocol violation, since the hazard unit prevents it. The block ignores it and leaves the in-flight op undisturbed.
- op NONE with start=1: no effect.
- Arithmetic rules:
  - mult: signed 32×32→64, HI=upper, LO=lower.
  - multu: unsigned 32×32→64, HI=upper, LO=lower.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B==0): the op is accepted and busy runs the full DIV_CYCLES. HI/LO are left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Operands are sampled only at the accepting edge. Later changes on A/B have no effect.
- Reset asserted mid-operation: aborts immediately; HI/LO=0, busy=0.

Decomposition:
- Shared package mdu_pkg holds:
  - op encoding: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6;
  - state encoding: IDLE=0, BUSY=1;
  - default MULT_CYCLES and DIV_CYCLES constants.
- One natural sub-module, mdu_arith: purely combinational. Takes op, A, B; produces res_hi, res_lo and div_zero. ex_mdu owns all state.

Test Plan:
- mult, A=0xFFFFFFFE(-2), B=3, pulse start → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, A=-7 (0xFFFFFFF9), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with divu, A=7, B=0 → busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO updated one edge each; busy never asserted.
- start=1 (mult) together with req=1 → busy stays 0, HI/LO unchanged. Start div, raise req at cycle 3 → div still completes at cycle 10.
- Start div, assert reset at cycle 4 (between edges) → busy, HI and LO drop to 0 immediately; a new mult after release behaves normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default latencies for the EX-stage multiply/divide unit
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_div_op(mdu_op_e op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction

    function automatic logic is_long_op(mdu_op_e op);
        return op == MDU_MULT || op == MDU_MULTU || is_div_op(op);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit product / quotient-remainder generator for one MDU op
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [32:0] w_sa;
    logic signed [32:0] w_sd;
    logic        [31:0] w_ud;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;

    assign w_sprod  = 64'($signed(a)) * 64'($signed(b));
    assign w_uprod  = {32'd0, a} * {32'd0, b};
    // 33-bit signed operands keep 0x80000000 / -1 representable; its low 32 bits give the required result
    assign w_sa     = {a[31], a};
    assign w_sd     = (b == 32'd0) ? 33'sd1 : {b[31], b};
    assign w_ud     = (b == 32'd0) ? 32'd1 : b;
    assign w_sq     = 32'(w_sa / w_sd);
    assign w_sr     = 32'(w_sa % w_sd);
    assign w_uq     = a / w_ud;
    assign w_ur     = a % w_ud;
    assign div_zero = is_div_op(op) && (b == 32'd0);

    // select HI/LO halves for the requested op; mthi/mtlo pass A through
    always_comb begin
        res_hi = op == MDU_MULT  ? w_sprod[63:32] :
                 op == MDU_MULTU ? w_uprod[63:32] :
                 op == MDU_DIV   ? w_sr           :
                 op == MDU_DIVU  ? w_ur           : a;
        res_lo = op == MDU_MULT  ? w_sprod[31:0]  :
                 op == MDU_MULTU ? w_uprod[31:0]  :
                 op == MDU_DIV   ? w_sq           :
                 op == MDU_DIVU  ? w_uq           : a;
    end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning HI/LO with fixed-latency mult/div and busy for the hazard unit
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] L_MC = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DC = 4'(DIV_CYCLES);

    mdu_state_e  r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [31:0] r_pend_hi, w_pend_hi_nxt;
    logic [31:0] r_pend_lo, w_pend_lo_nxt;
    logic        r_pend_dz, w_pend_dz_nxt;
    mdu_op_e     w_op;
    logic        w_go;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div_zero;

    assign w_op = mdu_op_e'(op);
    // a cancelled (req) or hazard-violating (busy) start never reaches the datapath
    assign w_go = start && !req && r_state == IDLE;

    mdu_arith u_arith (
        .op       (w_op),
        .a        (A),
        .b        (B),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo),
        .div_zero (w_div_zero)
    );

    // next-state: accept long ops or mthi/mtlo in IDLE, count down and retire in BUSY
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_dz_nxt = r_pend_dz;
        if (r_state == IDLE) begin
            if (w_go && is_long_op(w_op)) begin
                w_state_nxt   = BUSY;
                w_cnt_nxt     = is_div_op(w_op) ? L_DC : L_MC;
                w_pend_hi_nxt = w_res_hi;
                w_pend_lo_nxt = w_res_lo;
                w_pend_dz_nxt = w_div_zero;
            end
            w_hi_nxt = (w_go && w_op == MDU_MTHI) ? A : r_hi;
            w_lo_nxt = (w_go && w_op == MDU_MTLO) ? A : r_lo;
        end else begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
                w_hi_nxt    = r_pend_dz ? r_hi : r_pend_hi;
                w_lo_nxt    = r_pend_dz ? r_lo : r_pend_lo;
            end
        end
    end

    // state and architectural registers; reset clears everything without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_dz <= w_pend_dz_nxt;
        end
    end

    assign busy = r_state == BUSY;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: scoreboard bench for ex_mdu with directed corner cases and randomized ops
module tb_ex_mdu;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    ex_mdu dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: architectural HI/LO after the op, pushed with expected busy length
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic rq);
        longint      p;
        longint      r;
        logic [63:0] u;
        exp_t        e;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; req = rq;
        if (!rq) begin
            e.len = -1;
            case (o)
                MDU_MULT: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    m_hi = p[63:32]; m_lo = p[31:0]; e.len = 5;
                end
                MDU_MULTU: begin
                    u = 64'(a) * 64'(b);
                    m_hi = u[63:32]; m_lo = u[31:0]; e.len = 5;
                end
                MDU_DIV: begin
                    if (b != 0) begin
                        p = longint'($signed(a)) / longint'($signed(b));
                        r = longint'($signed(a)) % longint'($signed(b));
                        m_lo = p[31:0]; m_hi = r[31:0];
                    end
                    e.len = 10;
                end
                MDU_DIVU: begin
                    if (b != 0) begin
                        m_lo = a / b; m_hi = a % b;
                    end
                    e.len = 10;
                end
                MDU_MTHI: begin m_hi = a; e.len = 0; end
                MDU_MTLO: begin m_lo = a; e.len = 0; end
                default: e.len = -1;
            endcase
            if (e.len >= 0) begin
                e.hi = m_hi; e.lo = m_lo;
                q.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0; req = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom_range(0, 6));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++; fails++;
            $display("FAIL wait_idle: timeout busy=%0b pending=%0d", busy, q.size());
        end
    endtask

    // monitor: on busy falling or an accepted mthi/mtlo, pop expected and compare
    initial begin : mon
        int          cnt = 0;
        logic        lb = 1'b0;
        logic        ps;
        logic        pr;
        logic [2:0]  po;
        exp_t        e;
        forever begin
            @(posedge clk);
            ps = start; pr = req; po = op;
            #1;
            if (reset) begin
                cnt = 0; lb = 1'b0;
                continue;
            end
            if (busy) cnt++;
            if ((lb && !busy) || (ps && !pr && !lb && (po == MDU_MTHI || po == MDU_MTLO))) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_event: HI=%h LO=%h busy_len=%0d", HI, LO, cnt);
                end else begin
                    e = q.pop_front();
                    chk("hi", 64'(HI), 64'(e.hi));
                    chk("lo", 64'(LO), 64'(e.lo));
                    chk("busy_len", 64'(cnt), 64'(e.len));
                end
                cnt = 0;
            end
            lb = busy;
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  o;
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_hi", 64'(HI), 64'(0));
        chk("reset_lo", 64'(LO), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0); wait_idle();
        chk("mult_hi", 64'(HI), 64'hFFFFFFFF);
        chk("mult_lo", 64'(LO), 64'hFFFFFFFA);
        issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle();
        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
        chk("div_lo", 64'(LO), 64'hFFFFFFFD);
        chk("div_hi", 64'(HI), 64'hFFFFFFFF);
        issue(MDU_DIVU, 32'd7, 32'd0, 1'b0); wait_idle();
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle();
        chk("ovf_lo", 64'(LO), 64'h80000000);
        chk("ovf_hi", 64'(HI), 64'h0);
        issue(MDU_MTHI, 32'h12345678, 32'd0, 1'b0);
        issue(MDU_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0); wait_idle();

        issue(MDU_MULT, 32'd1000, 32'd1000, 1'b1);
        chk("req_busy", 64'(busy), 64'(0));
        chk("req_hi", 64'(HI), 64'h12345678);
        chk("req_lo", 64'(LO), 64'h9ABCDEF0);
        issue(MDU_NONE, 32'd5, 32'd6, 1'b0);
        chk("none_hi", 64'(HI), 64'(m_hi));

        issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
        req = 1'b1;
        repeat (3) @(negedge clk);
        req = 1'b0;
        start = 1'b1; op = MDU_MULTU; A = 32'd9; B = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        issue(MDU_DIV, 32'd1234567, 32'd89, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hi", 64'(HI), 64'(0));
        chk("rst_lo", 64'(LO), 64'(0));
        q.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        issue(MDU_MULT, 32'd12345, 32'hFFFFFF00, 1'b0); wait_idle();

        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom_range(0, 6));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            issue(o, a, b, $urandom_range(0, 7) == 0);
            wait_idle();
        end
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
